// File: rtl/str_window_gen.sv
// rtl/str_window_gen.sv - sliding STR_SIZE-byte window generator for packetised byte streams
// Emits every stride-1 substring of each packet on a single-register valid/ready output.
module str_window_gen #(
   parameter int BYTE_W    = 8,
   parameter int STR_SIZE  = 3,
   parameter int WIN_CNT_W = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [BYTE_W-1:0]          byte_data_i,
   input  logic                       byte_valid_i,
   input  logic                       byte_sop_i,
   input  logic                       byte_eop_i,
   output logic                       byte_ready_o,
   output logic [STR_SIZE*BYTE_W-1:0] window_data_o,
   output logic                       window_valid_o,
   input  logic                       window_ready_i,
   output logic [WIN_CNT_W-1:0]       window_cnt_o
);

   localparam int WIN_W  = STR_SIZE * BYTE_W;
   localparam int FILL_W = $clog2(STR_SIZE + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [FILL_W-1:0] fill, fill_next;
   logic [WIN_W-1:0]  sr, sr_shifted;
   logic              acc;
   logic              load;
   logic              emit;

   assign byte_ready_o = !window_valid_o || window_ready_i;
   assign acc          = byte_valid_i && byte_ready_o;

   // Truncating cast drops the oldest byte; also valid when STR_SIZE == 1.
   assign sr_shifted = WIN_W'({sr, byte_data_i});

   always_comb begin
      state_next = state;
      fill_next  = fill;
      load       = 1'b0;
      emit       = 1'b0;
      if (acc) begin
         if (byte_sop_i) begin
            load      = 1'b1;
            fill_next = FILL_W'(1);
            if (STR_SIZE == 1) begin
               emit       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = FILL;
            end
         end else begin
            case (state)
               FILL: begin
                  load      = 1'b1;
                  fill_next = fill + FILL_W'(1);
                  if (fill == FILL_W'(STR_SIZE - 1)) begin
                     emit       = 1'b1;
                     state_next = RUN;
                  end
               end
               RUN: begin
                  load = 1'b1;
                  emit = 1'b1;
               end
               default: ;
            endcase
         end
         if (byte_eop_i) begin
            state_next = IDLE;
            fill_next  = '0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         fill  <= '0;
         sr    <= '0;
      end else begin
         state <= state_next;
         fill  <= fill_next;
         if (load) begin
            sr <= sr_shifted;
         end
      end
   end

   // New window and handoff in the same cycle keep valid high for back-to-back output.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         window_valid_o <= 1'b0;
         window_data_o  <= '0;
         window_cnt_o   <= '0;
      end else begin
         if (emit) begin
            window_valid_o <= 1'b1;
            window_data_o  <= sr_shifted;
         end else if (window_ready_i) begin
            window_valid_o <= 1'b0;
         end
         if (window_valid_o && window_ready_i) begin
            window_cnt_o <= window_cnt_o + WIN_CNT_W'(1);
         end
      end
   end

endmodule
